qos_tx_arb: RTL

Transmit-side counterpart of the QoS receive block. It accepts 12-bit words tagged by class in bits [11:10], buffers them in four per-class FIFOs, and merges them into a single push/data stream with round-robin arbitration. The output stream honours per-class pause (almost-full) from the far-end receiver. Like the receiver, it has an init/idle/active FSM, programmable occupancy thresholds and request-readable statistics counters.

---
 rtl/qos_tx_arb_if.sv | 28 ++
 rtl/qos_tx_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/qos_tx_arb_if.sv
// Stream and statistics bundle for the QoS transmit arbiter.
// The slave modport is the arbiter's view; the master modport is the driver's view.
interface qos_tx_arb_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
);
  logic              push_in;
  logic [DATA_W-1:0] data_in;
  logic [3:0]        pause_in;
  logic              push_out;
  logic [DATA_W-1:0] data_out;
  logic [3:0]        almost_full_out;
  logic [3:0]        almost_empty_out;
  logic              req;
  logic [2:0]        idx;
  logic              valid;
  logic [CNT_W-1:0]  data;

  modport slave (
    input  push_in, data_in, pause_in, req, idx,
    output push_out, data_out, almost_full_out, almost_empty_out, valid, data
  );

  modport master (
    output push_in, data_in, pause_in, req, idx,
    input  push_out, data_out, almost_full_out, almost_empty_out, valid, data
  );
endinterface

// File: rtl/qos_tx_arb.sv
// QoS transmit arbiter: four per-class FIFOs merged into one stream by
// round-robin, honouring per-class pause from the far end. Includes an
// init/idle/active FSM, latched occupancy thresholds and statistics counters.
module qos_tx_arb #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [3:0]        umbralHigh,
  input  logic [3:0]        umbralLow,
  qos_tx_arb_if.slave       bus,
  output logic              active_out,
  output logic              idle_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [4][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [4];
  logic [PTR_W-1:0]  rd_ptr_q [4];
  logic [OCC_W-1:0]  occ_q [4];
  logic [OCC_W-1:0]  occ_d [4];
  logic [3:0]        thr_high_q, thr_high_d;
  logic [3:0]        thr_low_q, thr_low_d;
  logic [1:0]        rr_q;
  logic [CNT_W-1:0]  sent_q [4];
  logic [CNT_W-1:0]  drop_q;
  logic              push_out_q;
  logic [DATA_W-1:0] data_out_q;
  logic [3:0]        af_q, af_d;
  logic [3:0]        ae_q, ae_d;
  logic              valid_q;
  logic [CNT_W-1:0]  data_q;

  logic [3:0]        elig_s;
  logic              pop_s;
  logic [1:0]        pop_cls_s;
  logic [1:0]        cand_s;
  logic [1:0]        wr_cls_s;
  logic              wr_en_s;
  logic              full_s;
  logic              accept_s;
  logic              drop_s;
  logic              any_d_s;
  logic [CNT_W-1:0]  stat_sel_s;

  assign wr_cls_s = bus.data_in[DATA_W-1 -: 2];
  assign wr_en_s  = bus.push_in && (state_q != ST_RESET);
  assign full_s   = (occ_q[wr_cls_s] == OCC_W'(DEPTH));
  // A full FIFO still takes the word when its head leaves on the same edge.
  assign accept_s = wr_en_s && (!full_s || (pop_s && (pop_cls_s == wr_cls_s)));
  assign drop_s   = wr_en_s && !accept_s;

  // Round-robin pick among non-empty, unpaused classes, starting after last grant.
  always_comb begin
    elig_s    = 4'b0000;
    pop_s     = 1'b0;
    pop_cls_s = 2'd0;
    cand_s    = 2'd0;
    for (int c = 0; c < 4; c++) begin
      elig_s[c] = (occ_q[c] != {OCC_W{1'b0}}) && !bus.pause_in[c];
    end
    if (state_q == ST_ACTIVE) begin
      for (int i = 0; i < 4; i++) begin
        cand_s = rr_q + 2'd1 + 2'(i);
        if (!pop_s && elig_s[cand_s]) begin
          pop_s     = 1'b1;
          pop_cls_s = cand_s;
        end else begin
          pop_s     = pop_s;
        end
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Post-edge occupancy, thresholds and the flags derived from them.
  always_comb begin
    any_d_s    = 1'b0;
    af_d       = 4'b0000;
    ae_d       = 4'b0000;
    thr_high_d = (state_q == ST_INIT) ? umbralHigh : thr_high_q;
    thr_low_d  = (state_q == ST_INIT) ? umbralLow  : thr_low_q;
    for (int c = 0; c < 4; c++) begin
      occ_d[c] = occ_q[c];
      if (accept_s && (wr_cls_s == 2'(c)) && !(pop_s && (pop_cls_s == 2'(c)))) begin
        occ_d[c] = occ_q[c] + OCC_W'(1);
      end else if (!(accept_s && (wr_cls_s == 2'(c))) && pop_s && (pop_cls_s == 2'(c))) begin
        occ_d[c] = occ_q[c] - OCC_W'(1);
      end else begin
        occ_d[c] = occ_q[c];
      end
      if (occ_d[c] != {OCC_W{1'b0}}) begin
        any_d_s = 1'b1;
      end else begin
        any_d_s = any_d_s;
      end
      af_d[c] = (occ_d[c] >= thr_high_d);
      ae_d[c] = (occ_d[c] <= thr_low_d);
    end
  end

  // FSM next-state: ACTIVE lingers one cycle after the last word leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (init)         state_d = ST_INIT;
        else if (any_d_s) state_d = ST_ACTIVE;
        else              state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (init)                    state_d = ST_INIT;
        else if (!any_d_s && !pop_s) state_d = ST_IDLE;
        else                         state_d = ST_ACTIVE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // Statistics counter select.
  always_comb begin
    stat_sel_s = {CNT_W{1'b0}};
    case (bus.idx)
      3'd0:    stat_sel_s = sent_q[0];
      3'd1:    stat_sel_s = sent_q[1];
      3'd2:    stat_sel_s = sent_q[2];
      3'd3:    stat_sel_s = sent_q[3];
      3'd4:    stat_sel_s = drop_q;
      default: stat_sel_s = {CNT_W{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // FIFO storage; emptiness is tracked by pointers, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (accept_s) mem_q[wr_cls_s][wr_ptr_q[wr_cls_s]] <= bus.data_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (!reset) begin
        wr_ptr_q[c] <= {PTR_W{1'b0}};
        rd_ptr_q[c] <= {PTR_W{1'b0}};
        occ_q[c]    <= {OCC_W{1'b0}};
      end else begin
        if (accept_s && (wr_cls_s == 2'(c))) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
        if (pop_s && (pop_cls_s == 2'(c)))   rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        occ_q[c] <= occ_d[c];
      end
    end
  end

  // Output stream, arbitration pointer, thresholds and occupancy flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      push_out_q <= 1'b0;
      data_out_q <= {DATA_W{1'b0}};
      rr_q       <= 2'd0;
      thr_high_q <= 4'd0;
      thr_low_q  <= 4'd0;
      af_q       <= 4'b0000;
      ae_q       <= 4'b1111;
    end else begin
      push_out_q <= pop_s;
      if (pop_s) begin
        data_out_q <= mem_q[pop_cls_s][rd_ptr_q[pop_cls_s]];
        rr_q       <= pop_cls_s;
      end
      thr_high_q <= thr_high_d;
      thr_low_q  <= thr_low_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end

  // Sent counters wrap; the drop counter saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 4; c++) sent_q[c] <= {CNT_W{1'b0}};
      drop_q <= {CNT_W{1'b0}};
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (pop_s && (pop_cls_s == 2'(c))) sent_q[c] <= sent_q[c] + CNT_W'(1);
      end
      if (drop_s && (drop_q != {CNT_W{1'b1}})) drop_q <= drop_q + CNT_W'(1);
    end
  end

  // Statistics read port: data holds its last value when no request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= {CNT_W{1'b0}};
    end else begin
      valid_q <= bus.req;
      if (bus.req) data_q <= stat_sel_s;
    end
  end

  assign bus.push_out         = push_out_q;
  assign bus.data_out         = data_out_q;
  assign bus.almost_full_out  = af_q;
  assign bus.almost_empty_out = ae_q;
  assign bus.valid            = valid_q;
  assign bus.data             = data_q;
  assign active_out           = (state_q == ST_ACTIVE);
  assign idle_out             = (state_q == ST_IDLE);

endmodule
